// File: rtl/sram_dist_2p_clr.sv
// Simple dual-port distributed RAM with byte-lane writes, registered read port and a clear sequencer.
// Optional per-lane even parity with a par_err read flag is enabled by defining SRAM_DIST_PARITY_EN.
module sram_dist_2p_clr #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    LANE_WIDTH     = 8,
    parameter int                    HEIGHT         = 128,
    parameter int                    ADDR_BITS      = 7,
    parameter int                    RDW_MODE       = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic                             wr_en,
    input  logic [ADDR_BITS-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_BITS-1:0]             rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
`ifdef SRAM_DIST_PARITY_EN
   ,output logic [DATA_WIDTH/LANE_WIDTH-1:0] par_err
`endif
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
`ifdef SRAM_DIST_PARITY_EN
    localparam int ROW_W = DATA_WIDTH + LANES;
`else
    localparam int ROW_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_BITS:0]   HEIGHT_L = (ADDR_BITS+1)'(HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(HEIGHT - 1);

    generate
        if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
            $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
        if ((1 << ADDR_BITS) < HEIGHT) begin : g_bad_addr
            $error("ADDR_BITS too small for HEIGHT");
        end
    endgenerate

    // Row layout is {lane parity, data}; without parity the row is data only.
    function automatic logic [ROW_W-1:0] make_row(input logic [DATA_WIDTH-1:0] d);
        logic [ROW_W-1:0] row;
        row = '0;
        row[DATA_WIDTH-1:0] = d;
`ifdef SRAM_DIST_PARITY_EN
        for (int i = 0; i < LANES; i++) row[DATA_WIDTH+i] = ^d[i*LANE_WIDTH +: LANE_WIDTH];
`endif
        return row;
    endfunction

    typedef enum logic {IDLE, CLEAR} state_t;

    (* ram_style = "distributed" *) logic [ROW_W-1:0] r_mem [HEIGHT];

    state_t                  r_state, w_next;
    logic                    r_init;
    logic [ADDR_BITS-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic                    w_busy, w_wr_in, w_rd_in, w_wr_act, w_rdw_hit;
    logic [ROW_W-1:0]        w_clr_row, w_wr_old, w_wr_row, w_rd_row;
    logic [DATA_WIDTH-1:0]   w_wr_merge;

    assign w_busy    = (r_state == CLEAR);
    assign busy      = w_busy;
    assign w_wr_in   = ({1'b0, wr_addr} < HEIGHT_L);
    assign w_rd_in   = ({1'b0, rd_addr} < HEIGHT_L);
    assign w_wr_act  = !w_busy && wr_en && w_wr_in;
    assign w_rdw_hit = w_wr_act && (wr_addr == rd_addr);
    assign w_clr_row = make_row(CLEAR_VALUE);
    assign w_wr_old  = r_mem[wr_addr];

    always_comb begin
        w_wr_merge = w_wr_old[DATA_WIDTH-1:0];
        for (int i = 0; i < LANES; i++)
            if (wr_be[i]) w_wr_merge[i*LANE_WIDTH +: LANE_WIDTH] = wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        w_wr_row = make_row(w_wr_merge);
    end

    // Write-first forwards the merged row; read-old sees the array before the edge.
    always_comb begin
        w_rd_row = r_mem[rd_addr];
        if (RDW_MODE == 1 && w_rdw_hit) w_rd_row = w_wr_row;
    end

    // r_init forces one sweep on the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_init  <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_init  <= 1'b0;
            r_cnt   <= (w_busy && w_next == CLEAR) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_init || clr_req) w_next = CLEAR;
            CLEAR:   if (r_cnt == LAST_ROW) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_busy)        r_mem[r_cnt]   <= w_clr_row;
        else if (w_wr_act) r_mem[wr_addr] <= w_wr_row;
    end

`ifdef SRAM_DIST_PARITY_EN
    logic [ROW_W-1:0] w_rd_recalc;
    logic [LANES-1:0] r_par_err;
    assign w_rd_recalc = make_row(w_rd_row[DATA_WIDTH-1:0]);
    assign par_err     = r_par_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_par_err <= '0;
        else if (!w_busy && rd_en && w_rd_in) r_par_err <= w_rd_recalc[ROW_W-1:DATA_WIDTH] ^ w_rd_row[ROW_W-1:DATA_WIDTH];
        else                                 r_par_err <= '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (!w_busy && rd_en) begin
            r_rd_data  <= w_rd_in ? w_rd_row[DATA_WIDTH-1:0] : '0;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_sram_dist_2p_clr.sv
// Directed bench: instance a = HEIGHT 128 / read-old, instance b = HEIGHT 100 / write-first, shared stimulus.
module tb_sram_dist_2p_clr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [6:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
    logic [15:0] rd_data_a, rd_data_b;
`ifdef SRAM_DIST_PARITY_EN
    logic [1:0]  par_err_a, par_err_b;
`endif
    int checks = 0, failures = 0;
    int na, nb;
    logic bad_a, bad_b;

    always #5 clk = ~clk;

    sram_dist_2p_clr #(.HEIGHT(128), .ADDR_BITS(7), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef SRAM_DIST_PARITY_EN
       ,.par_err(par_err_a)
`endif
    );

    sram_dist_2p_clr #(.HEIGHT(100), .ADDR_BITS(7), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef SRAM_DIST_PARITY_EN
       ,.par_err(par_err_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [6:0] a, input logic [15:0] ea, input logic [15:0] eb);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_va"}, rd_valid_a, 1);
        chk({tag, "_da"}, rd_data_a, ea);
        chk({tag, "_vb"}, rd_valid_b, 1);
        chk({tag, "_db"}, rd_data_b, eb);
    endtask

    // Counts busy cycles of both instances until both are idle, bounded.
    task automatic count_busy(output int ca, output int cb);
        ca = 0; cb = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            clr_req = 1'b0;
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b && ca > 0) break;
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_data_a", rd_data_a, 0);

        rst = 1'b0;
        count_busy(na, nb);
        chk("init_sweep_a", na, 128);
        chk("init_sweep_b", nb, 100);
        do_read("clr0", 7'd0, 16'h0000, 16'h0000);
        do_read("clr64", 7'd64, 16'h0000, 16'h0000);
        do_read("clr127", 7'd127, 16'h0000, 16'h0000);
        tick();
        chk("idle_valid_a", rd_valid_a, 0);
        chk("hold_data_a", rd_data_a, 0);

        do_write(7'd5, 16'hABCD, 2'b11);
        do_write(7'd5, 16'h1234, 2'b01);
        do_read("be", 7'd5, 16'hAB34, 16'hAB34);

        do_write(7'd9, 16'h1111, 2'b11);
        wr_en = 1'b1; wr_addr = 7'd9; wr_data = 16'h2222; wr_be = 2'b11;
        do_read("rdw_full", 7'd9, 16'h1111, 16'h2222);
        wr_en = 1'b0;
        do_read("rdw_after", 7'd9, 16'h2222, 16'h2222);
        wr_en = 1'b1; wr_addr = 7'd9; wr_data = 16'h4433; wr_be = 2'b01;
        do_read("rdw_part", 7'd9, 16'h2222, 16'h2233);
        wr_en = 1'b0;
        do_write(7'd9, 16'hFFFF, 2'b00);
        do_read("be_none", 7'd9, 16'h2233, 16'h2233);

        do_write(7'd10, 16'h0A0A, 2'b11);
        do_write(7'd11, 16'h0B0B, 2'b11);
        rd_en = 1'b1; rd_addr = 7'd10;
        wr_en = 1'b1; wr_addr = 7'd12; wr_data = 16'h0C0C; wr_be = 2'b11;
        tick();
        wr_en = 1'b0;
        chk("b2b0_a", {rd_valid_a, rd_data_a}, {1'b1, 16'h0A0A});
        rd_addr = 7'd11;
        tick();
        chk("b2b1_b", {rd_valid_b, rd_data_b}, {1'b1, 16'h0B0B});
        rd_addr = 7'd12;
        tick();
        rd_en = 1'b0;
        chk("b2b2_a", {rd_valid_a, rd_data_a}, {1'b1, 16'h0C0C});
        tick();
        chk("b2b_end", {rd_valid_a, rd_data_a}, {1'b0, 16'h0C0C});

        for (int r = 0; r < 8; r++) do_write(7'(r), 16'hFFFF, 2'b11);
        do_read("pre_clr", 7'd0, 16'hFFFF, 16'hFFFF);
        clr_req = 1'b1;
        na = 0; nb = 0; bad_a = 1'b0; bad_b = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            clr_req = (k == 50);
            if (busy_a) na++;
            if (busy_b) nb++;
            if (busy_a && (rd_valid_a || rd_data_a !== 16'hFFFF)) bad_a = 1'b1;
            if (busy_b && (rd_valid_b || rd_data_b !== 16'hFFFF)) bad_b = 1'b1;
            wr_en = busy_b; wr_addr = 7'd2; wr_data = 16'h7777; wr_be = 2'b11;
            rd_en = busy_b; rd_addr = 7'd2;
            if (!busy_a && !busy_b) break;
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        chk("req_sweep_a", na, 128);
        chk("req_sweep_b", nb, 100);
        chk("busy_quiet_a", bad_a, 0);
        chk("busy_quiet_b", bad_b, 0);
        do_read("post2", 7'd2, 16'h0000, 16'h0000);
        do_read("post7", 7'd7, 16'h0000, 16'h0000);
        do_read("post5", 7'd5, 16'h0000, 16'h0000);

        do_write(7'd90, 16'hBEEF, 2'b11);
        do_read("pre_abort", 7'd90, 16'hBEEF, 16'hBEEF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (39) tick();
        chk("mid_busy_a", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy_a", busy_a, 0);
        chk("abort_busy_b", busy_b, 0);
        chk("abort_valid_b", rd_valid_b, 0);
        chk("abort_data_a", rd_data_a, 0);
        tick();
        rst = 1'b0;
        count_busy(na, nb);
        chk("re_sweep_a", na, 128);
        chk("re_sweep_b", nb, 100);
        do_read("re90", 7'd90, 16'h0000, 16'h0000);

        do_write(7'd120, 16'h5555, 2'b11);
        do_read("oor120", 7'd120, 16'h5555, 16'h0000);
        do_read("oor_alias", 7'd20, 16'h0000, 16'h0000);
        do_write(7'd99, 16'h9999, 2'b11);
        do_read("last_row", 7'd99, 16'h9999, 16'h9999);

`ifdef SRAM_DIST_PARITY_EN
        do_write(7'd3, 16'h00FF, 2'b11);
        do_write(7'd4, 16'h00FF, 2'b11);
        dut_a.r_mem[3] = dut_a.r_mem[3] ^ 18'h00001;
        do_read("par3", 7'd3, 16'h00FE, 16'h00FF);
        chk("par3_err_a", par_err_a, 2'b01);
        chk("par3_err_b", par_err_b, 2'b00);
        do_read("par4", 7'd4, 16'h00FF, 16'h00FF);
        chk("par4_err_a", par_err_a, 2'b00);
        tick();
        chk("par_idle_a", par_err_a, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_dist_2p_clr.md
Name: sram_dist_2p_clr

Overview:
- Parametrised successor to the single-port distributed-RAM bank model.
- Simple dual-port memory: one write port with byte-lane enables, and one independent read port with a registered output and a valid flag.
- Selectable read-during-write behaviour, plus a hardware clear sequencer that zeroes the array after reset or on request.
- Used as weight/Q-value scratch storage in the RL accelerator datapath.

Parameters:
- DATA_WIDTH, 16, data width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per byte-enable lane.
- HEIGHT, 128, number of rows; need not be a power of 2.
- ADDR_BITS, 7, address width; must satisfy 2**ADDR_BITS >= HEIGHT.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read-old, 1 = write-first.
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written by the clear sequencer.
- CLEAR_ON_RESET, 1, 1 = run a clear sweep automatically after reset deasserts.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  single-cycle request to start a clear sweep.
- busy  out  1  high while the clear sweep runs.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_BITS  write row.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/LANE_WIDTH  lane enables; bit i covers data[i*LANE_WIDTH +: LANE_WIDTH].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_BITS  read row.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid this cycle.

Behaviour:
- Storage is distributed RAM (ram_style "distributed"). The array itself is not reset; only control state and output registers are.
- Reset values: busy=0, rd_data=0, rd_valid=0, FSM=IDLE, clear counter=0.
- FSM states are IDLE and CLEAR.
- IDLE -> CLEAR:
  - on the first clock edge after rst deasserts, when CLEAR_ON_RESET=1;
  - otherwise when clr_req=1 is sampled in IDLE.
- CLEAR:
  - writes CLEAR_VALUE to row cnt each cycle, with cnt running 0..HEIGHT-1;
  - the sweep takes exactly HEIGHT cycles with busy=1 throughout;
  - returns to IDLE after writing row HEIGHT-1; busy=0 on the following cycle.
- clr_req while busy=1 is ignored; the sweep does not restart.
- rst asserted mid-sweep aborts it immediately. Array contents are then undefined, and a new sweep runs if CLEAR_ON_RESET=1.
- While busy=1:
  - wr_en and rd_en are ignored; no user write occurs;
  - rd_valid=0; rd_data holds its last value.
- Write (busy=0, wr_en=1, wr_addr<HEIGHT): lanes with wr_be[i]=1 update at the clock edge; other lanes are unchanged. wr_be=0 gives a no-op.
- Read (busy=0, rd_en=1):
  - rd_data and rd_valid=1 appear on the cycle after rd_en (1-cycle latency);
  - rd_valid=0 on any cycle that does not follow an accepted read;
  - rd_data holds its value when rd_en=0.
- Reads and writes are fully independent and can be accepted every cycle (throughput 1 + 1 per cycle).
- Same-address read and write in one cycle:
  - RDW_MODE=0: rd_data returns pre-write contents;
  - RDW_MODE=1: rd_data returns the merge (new data on enabled lanes, old data elsewhere).
- Out-of-range address (>= HEIGHT): the write is dropped; the read returns 0 with rd_valid=1.
- Width rule: number of lanes = DATA_WIDTH/LANE_WIDTH. Elaboration fails ($error) if DATA_WIDTH % LANE_WIDTH != 0 or 2**ADDR_BITS < HEIGHT.

Optional Feature:
- Macro: SRAM_DIST_PARITY_EN.
- Defined:
  - each row stores one extra even-parity bit per lane, computed on the merged lane data at write and clear time;
  - the read port recomputes parity and drives an extra output par_err (width = lane count, reset 0), registered and aligned with rd_data; bit i=1 means a lane-i parity mismatch;
  - par_err is only meaningful when rd_valid=1 and is 0 otherwise;
  - the bench injects errors via hierarchical force on the array.
- Not defined: no parity storage and no par_err port; the array is DATA_WIDTH wide.

Test Plan:
- Clear after reset: rst pulse, CLEAR_ON_RESET=1, HEIGHT=128 -> busy high exactly 128 cycles; then reads of rows 0, 64, 127 -> rd_data=0x0000 with rd_valid=1 one cycle after rd_en.
- Byte enables: write 0xABCD to row 5 with wr_be=2'b11, then 0x1234 with wr_be=2'b01 -> read row 5 returns 0xAB34.
- Read-during-write: row 9 holds 0x1111; same cycle write 0x2222 (wr_be=2'b11) and read row 9 -> RDW_MODE=0 returns 0x1111; RDW_MODE=1 returns 0x2222; a later read returns 0x2222.
- Clear during traffic: fill rows with 0xFFFF, pulse clr_req, issue wr_en/rd_en during busy -> no rd_valid while busy; post-sweep all rows read 0; writes issued during busy are absent.
- Reset mid-sweep and out-of-range: HEIGHT=100, ADDR_BITS=7; assert rst at sweep cycle 40 -> busy=0, rd_valid=0 immediately, and the sweep restarts from row 0 for 100 cycles. Write 0x5555 to row 120 -> dropped; read row 120 returns 0x0000 with rd_valid=1.
- Parity (SRAM_DIST_PARITY_EN): write 0x00FF to row 3, force-flip bit 0 of stored row 3, read -> par_err=2'b01 with rd_valid=1; an unflipped row reads with par_err=2'b00.
